// File: rtl/aidan_mcnay_div_pkg.sv
`default_nettype none
// ============================================================================
// aidan_mcnay_div_pkg : FSM state type and counter-width helper for the iterative divider
// Rev 1.0
// ============================================================================
package aidan_mcnay_div_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

  // Counter width needed to index nbits restoring steps
  function automatic int CNT_W(input int nbits);
    return $clog2(nbits);
  endfunction

endpackage
`default_nettype wire

// File: rtl/aidan_mcnay_div_step.sv
`default_nettype none
// ============================================================================
// aidan_mcnay_div_step : one combinational radix-2 restoring division step
// Rev 1.0
// ============================================================================
module aidan_mcnay_div_step
  import aidan_mcnay_div_pkg::*;
#(
  parameter int nbits = 32
) (
  input  logic [nbits:0]   rem,
  input  logic             q_msb,
  input  logic [nbits-1:0] div,
  output logic [nbits:0]   rem_next,
  output logic             q_bit
);

  logic [nbits+1:0] w_p;
  logic             w_ge;

  // A non-negative trial difference is the same test as p >= div
  assign w_p      = {rem, q_msb};
  assign w_ge     = (w_p >= {2'b00, div});
  assign q_bit    = w_ge;
  assign rem_next = w_ge ? (nbits+1)'(w_p - {2'b00, div}) : w_p[nbits:0];

endmodule
`default_nettype wire

// File: rtl/aidan_mcnay_iter_divrem.sv
`default_nettype none
// ============================================================================
// aidan_mcnay_iter_divrem : multi-cycle restoring unsigned divider, val/rdy streams
// Optional macro ITER_DIV_EARLY_EXIT_EN skips iteration when opa < opb.  Rev 1.0
// ============================================================================
module aidan_mcnay_iter_divrem
  import aidan_mcnay_div_pkg::*;
#(
  parameter int nbits = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [nbits-1:0] opa,
  input  logic [nbits-1:0] opb,
  input  logic             istream_val,
  output logic             istream_rdy,
  output logic [nbits-1:0] result,
  output logic [nbits-1:0] remainder,
  output logic             ostream_val,
  input  logic             ostream_rdy
);

  localparam int CW = CNT_W(nbits);

  div_state_t       r_state;
  div_state_t       w_state_next;
  logic [nbits-1:0] r_q;
  logic [nbits-1:0] r_div;
  logic [nbits:0]   r_rem;
  logic [CW-1:0]    r_cnt;

  logic             w_last;
  logic             w_early;
  logic             w_q_bit;
  logic [nbits:0]   w_rem_next;

  assign w_last = (r_cnt == CW'(nbits - 1));

`ifdef ITER_DIV_EARLY_EXIT_EN
  assign w_early = (opb != '0) && (opa < opb);
`else
  assign w_early = 1'b0;
`endif

  aidan_mcnay_div_step #(.nbits(nbits)) u_step (
    .rem      (r_rem),
    .q_msb    (r_q[nbits-1]),
    .div      (r_div),
    .rem_next (w_rem_next),
    .q_bit    (w_q_bit)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= DIV_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      DIV_IDLE: if (istream_val) w_state_next = w_early ? DIV_DONE : DIV_CALC;
      DIV_CALC: if (w_last)      w_state_next = DIV_DONE;
      DIV_DONE: if (ostream_rdy) w_state_next = DIV_IDLE;
      default:                   w_state_next = DIV_IDLE;
    endcase
  end

  always_comb begin
    istream_rdy = (r_state == DIV_IDLE);
    ostream_val = (r_state == DIV_DONE);
  end

  // Outputs only load on the way into DONE, so a partial quotient is never visible
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q       <= '0;
      r_div     <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      result    <= '0;
      remainder <= '0;
    end else begin
      case (r_state)
        DIV_IDLE: begin
          if (istream_val) begin
            r_q   <= opa;
            r_div <= opb;
            r_rem <= '0;
            r_cnt <= '0;
            if (w_early) begin
              result    <= '0;
              remainder <= opa;
            end
          end
        end
        DIV_CALC: begin
          r_q   <= {r_q[nbits-2:0], w_q_bit};
          r_rem <= w_rem_next;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            result    <= {r_q[nbits-2:0], w_q_bit};
            remainder <= w_rem_next[nbits-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aidan_mcnay_iter_divrem.sv
`default_nettype none
// ============================================================================
// tb_aidan_mcnay_iter_divrem : directed checks at nbits=32 plus a stalled stream at nbits=8
// Rev 1.0
// ============================================================================
module tb_aidan_mcnay_iter_divrem;

`ifdef ITER_DIV_EARLY_EXIT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 33;
`endif
  localparam int N_RAND = 500;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [31:0] opa, opb, result, remainder;
  logic        istream_val, istream_rdy, ostream_val, ostream_rdy;
  logic [7:0]  opa8, opb8, result8, remainder8;
  logic        val8, rdy8, oval8, ordy8;

  aidan_mcnay_iter_divrem #(.nbits(32)) dut (
    .clk (clk), .reset (reset), .opa (opa), .opb (opb),
    .istream_val (istream_val), .istream_rdy (istream_rdy),
    .result (result), .remainder (remainder),
    .ostream_val (ostream_val), .ostream_rdy (ostream_rdy)
  );

  aidan_mcnay_iter_divrem #(.nbits(8)) dut8 (
    .clk (clk), .reset (reset), .opa (opa8), .opb (opb8),
    .istream_val (val8), .istream_rdy (rdy8),
    .result (result8), .remainder (remainder8),
    .ostream_val (oval8), .ostream_rdy (ordy8)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the accept edge
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    chk("rdy_idle", 64'(istream_rdy), 64'd1);
    opa = a; opb = b; istream_val = 1'b1;
    @(negedge clk);
    istream_val = 1'b0; opa = '0; opb = '0;
  endtask

  // Latency counts the accepting posedge as 1
  task automatic wait_done(output int lat, output bit busy_ok);
    lat = 1; busy_ok = 1'b1;
    while (!ostream_val && lat < 100) begin
      if (istream_rdy) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    if (!ostream_val) chk("timeout", 64'd0, 64'd1);
  endtask

  task automatic pop();
    ostream_rdy = 1'b1;
    @(negedge clk);
    ostream_rdy = 1'b0;
    chk("val_drop", 64'(ostream_val), 64'd0);
    chk("rdy_back", 64'(istream_rdy), 64'd1);
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eq, input logic [31:0] er, input int elat);
    int lat;
    bit busy_ok;
    launch(a, b);
    wait_done(lat, busy_ok);
    chk({tag, "_q"},   64'(result),    64'(eq));
    chk({tag, "_r"},   64'(remainder), 64'(er));
    chk({tag, "_lat"}, 64'(lat),       64'(elat));
    if (elat > 1) chk({tag, "_busy"}, 64'(busy_ok), 64'd1);
    pop();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  lat;
    bit  busy_ok;
    bit  stable;

    reset = 1'b0;
    opa = '0; opb = '0; istream_val = 1'b0; ostream_rdy = 1'b0;
    opa8 = '0; opb8 = '0; val8 = 1'b0; ordy8 = 1'b0;
    #2;
    chk("rst_rdy",  64'(istream_rdy), 64'd1);
    chk("rst_val",  64'(ostream_val), 64'd0);
    chk("rst_q",    64'(result),      64'd0);
    chk("rst_r",    64'(remainder),   64'd0);
    chk("rst_rdy8", 64'(rdy8),        64'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run("t1_100_7", 32'd100, 32'd7, 32'd14, 32'd2, 33);

    run("t2_5_0",      32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5, 33);
    run("t2_max_1",    32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0, 33);
    run("t2_max_max",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         32'd0, 33);
    run("t2_1e6_999",  32'd1000000,   32'd999,       32'd1001,      32'd1, 33);
    run("t2_0_0",      32'd0,         32'd0,         32'hFFFF_FFFF, 32'd0, 33);

    // Backpressure: hold DONE while offering a new operand that must be ignored
    launch(32'hDEAD_BEEF, 32'h10);
    wait_done(lat, busy_ok);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      istream_val = 1'b1; opa = 32'd1; opb = 32'd1;
      @(negedge clk);
      if (result !== 32'h0DEA_DBEE || remainder !== 32'hF ||
          ostream_val !== 1'b1 || istream_rdy !== 1'b0) stable = 1'b0;
    end
    istream_val = 1'b0;
    chk("t3_stable", 64'(stable),    64'd1);
    chk("t3_q",      64'(result),    64'h0DEA_DBEE);
    chk("t3_r",      64'(remainder), 64'hF);
    pop();
    @(negedge clk);
    chk("t3_no_new", 64'(ostream_val), 64'd0);
    chk("t3_held_q", 64'(result),      64'h0DEA_DBEE);

    // Reset in the middle of CALC clears outputs without a clock edge
    launch(32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t4_val", 64'(ostream_val), 64'd0);
    chk("t4_q",   64'(result),      64'd0);
    chk("t4_r",   64'(remainder),   64'd0);
    chk("t4_rdy", 64'(istream_rdy), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t4_idle", 64'(ostream_val), 64'd0);
    run("t4_91_13", 32'd91, 32'd13, 32'd7, 32'd0, 33);

    run("t5_3_10",    32'd3,   32'd10,  32'd0, 32'd3,   EARLY_LAT);
    run("t5_200_201", 32'd200, 32'd201, 32'd0, 32'd200, EARLY_LAT);

    // nbits=8 stream with random stalls on both sides
    begin : b_rand
      logic [7:0] qa[$];
      logic [7:0] qb[$];
      logic [7:0] a, b;
      int  sent, got, cyc;
      bit  pend;
      sent = 0; got = 0; cyc = 0; pend = 1'b0;
      while (got < N_RAND && cyc < 30000) begin
        @(negedge clk);
        cyc++;
        if (!pend) begin
          if (sent < N_RAND && $urandom_range(0, 3) != 0) begin
            opa8 = 8'($urandom);
            opb8 = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
            val8 = 1'b1;
            pend = 1'b1;
          end else begin
            val8 = 1'b0;
          end
        end
        ordy8 = ($urandom_range(0, 2) != 0);
        if (val8 && rdy8) begin
          qa.push_back(opa8);
          qb.push_back(opb8);
          sent++;
          pend = 1'b0;
        end
        if (oval8 && ordy8) begin
          if (qa.size() == 0) begin
            chk("r8_dup", 64'd1, 64'd0);
          end else begin
            a = qa.pop_front();
            b = qb.pop_front();
            chk("r8_q", 64'(result8),    64'((b == 8'd0) ? 8'hFF : a / b));
            chk("r8_r", 64'(remainder8), 64'((b == 8'd0) ? a : a % b));
          end
          got++;
        end
      end
      val8 = 1'b0; ordy8 = 1'b0;
      chk("r8_got",   64'(got),       64'(N_RAND));
      chk("r8_sent",  64'(sent),      64'(N_RAND));
      chk("r8_queue", 64'(qa.size()), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
